// File: rtl/mul_addtree_pkg.sv
// mul_addtree_pkg: shared width default and latency helper for mul_addtree_pipe
package mul_addtree_pkg;
  localparam int DEF_WIDTH = 4;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int latency(input int width);
    return clog2(width) + 1;
  endfunction
endpackage

// File: rtl/mul_addtree_level.sv
// mul_addtree_level: one registered pairwise-adder level of the reduction tree
// ports: clk, clr (async active-low), en (advance), v_in/rows_in (N_IN rows of W bits),
//        v_out/rows_out (N_IN/2 registered pair sums, truncated to W bits)
module mul_addtree_level #(
  parameter int N_IN = 4,
  parameter int W = 8
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    v_in,
  input  logic [N_IN-1:0][W-1:0]  rows_in,
  output logic                    v_out,
  output logic [N_IN/2-1:0][W-1:0] rows_out
);
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      v_out <= 1'b0;
      rows_out <= '0;
    end else if (en) begin
      v_out <= v_in;
      for (int j = 0; j < N_IN / 2; j++) rows_out[j] <= rows_in[2*j] + rows_in[2*j+1];
    end
endmodule

// File: rtl/mul_addtree_pipe.sv
// mul_addtree_pipe: pipelined add-tree multiplier with valid/ready and global stall
// ports: clk, clr (async active-low), in_valid/in_ready/x/y (operands, WIDTH each),
//        out_valid/out_ready/out (2*WIDTH product), busy (any stage valid)
// MUL_ADDTREE_SIGNED_EN: when defined, x and y are two's complement
module mul_addtree_pipe
  import mul_addtree_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);
  localparam int LEVELS = clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;
  logic stall;
  logic v0;
  logic [W2-1:0] ext;
  logic [WIDTH-1:0][W2-1:0] pp, pp_q;
  // heap layout: node n = node 2n + node 2n+1; leaves are WIDTH..2*WIDTH-1, root is node 1
  logic [2*WIDTH-1:1][W2-1:0] node;
  logic [LEVELS:0] v;
  assign stall = out_valid & ~out_ready;
  assign in_ready = ~stall;
`ifdef MUL_ADDTREE_SIGNED_EN
  assign ext = {{WIDTH{x[WIDTH-1]}}, x};
`else
  assign ext = {{WIDTH{1'b0}}, x};
`endif
  always_comb begin
    for (int i = 0; i < WIDTH; i++) pp[i] = y[i] ? ext << i : '0;
`ifdef MUL_ADDTREE_SIGNED_EN
    // the sign bit of y carries negative weight
    pp[WIDTH-1] = y[WIDTH-1] ? -(ext << (WIDTH - 1)) : '0;
`endif
  end
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      v0 <= 1'b0;
      pp_q <= '0;
    end else if (!stall) begin
      v0 <= in_valid;
      pp_q <= pp;
    end
  assign node[2*WIDTH-1:WIDTH] = pp_q;
  assign v[0] = v0;
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    mul_addtree_level #(.N_IN(WIDTH >> (k - 1)), .W(W2)) u_lvl (
      .clk(clk),
      .clr(clr),
      .en(~stall),
      .v_in(v[k-1]),
      .rows_in(node[2*(WIDTH>>(k-1))-1 : (WIDTH>>(k-1))]),
      .v_out(v[k]),
      .rows_out(node[2*(WIDTH>>k)-1 : (WIDTH>>k)])
    );
  end
  assign out = node[1];
  assign out_valid = v[LEVELS];
  assign busy = |v;
endmodule

// File: tb/tb_mul_addtree_pipe.sv
// tb_mul_addtree_pipe: directed self-checking bench for mul_addtree_pipe (WIDTH 4 and 8)
module tb_mul_addtree_pipe;
  import mul_addtree_pkg::*;
`ifdef MUL_ADDTREE_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  localparam int LAT4 = latency(4);
  localparam int LAT8 = latency(8);
  logic clk = 1'b0;
  logic clr = 1'b0;
  logic in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, busy4;
  logic [3:0] x4 = '0, y4 = '0;
  logic [7:0] out4;
  logic in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, busy8;
  logic [7:0] x8 = '0, y8 = '0;
  logic [15:0] out8;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mul_addtree_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .clr(clr), .in_valid(in_valid4), .in_ready(in_ready4), .x(x4), .y(y4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out(out4), .busy(busy4)
  );
  mul_addtree_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .clr(clr), .in_valid(in_valid8), .in_ready(in_ready8), .x(x8), .y(y8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out(out8), .busy(busy8)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] xa(input int m);
    return m == 0 ? 8'hFF : m == 1 ? 8'h80 : 8'(m * 37 + 5);
  endfunction
  function automatic logic [7:0] yb(input int m);
    return m == 0 ? 8'hFF : m == 1 ? 8'h80 : 8'(m * 91 + 3);
  endfunction
  function automatic logic [15:0] exp8(input int m);
    logic [7:0] a, b;
    a = xa(m);
    b = yb(m);
    return SGN ? 16'($signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b})) : 16'({8'b0, a} * {8'b0, b});
  endfunction
  task automatic run_one(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    @(posedge clk);
    #1 x4 = a;
    y4 = b;
    in_valid4 = 1'b1;
    @(negedge clk);
    check({tag, "_rdy"}, 16'(in_ready4), 16'd1);
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    for (int c = 1; c <= LAT4 + 1; c++) begin
      @(negedge clk);
      check({tag, "_vld"}, 16'(out_valid4), 16'(c == LAT4));
      if (c == LAT4) check({tag, "_out"}, 16'(out4), 16'(exp));
      if (c == 1) check({tag, "_busy"}, 16'(busy4), 16'd1);
    end
  endtask
  initial begin
    #12;
    check("rst_vld", 16'(out_valid4), 16'd0);
    check("rst_out", 16'(out4), 16'd0);
    check("rst_busy", 16'(busy4), 16'd0);
    check("rst_rdy", 16'(in_ready4), 16'd1);
    check("rst_vld8", 16'(out_valid8), 16'd0);
    @(negedge clk);
    clr = 1'b1;
    run_one("ff", 4'hF, 4'hF, SGN ? 8'h01 : 8'hE1);
    run_one("x0", 4'h0, 4'h9, 8'h00);
    run_one("y0", 4'h9, 4'h0, 8'h00);
    run_one("one", 4'h1, 4'h1, 8'h01);
    run_one("neg", 4'h8, 4'h7, SGN ? 8'hC8 : 8'h38);
    @(posedge clk);
    #1 in_valid4 = 1'b1;
    x4 = 4'd2;
    y4 = 4'd3;
    @(posedge clk);
    #1 x4 = 4'd5;
    y4 = 4'd7;
    @(posedge clk);
    #1 x4 = 4'd6;
    y4 = 4'd4;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    out_ready4 = 1'b0;
    @(posedge clk);
    #1 in_valid4 = 1'b1;
    x4 = 4'd3;
    y4 = 4'd3;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_vld", 16'(out_valid4), 16'd1);
      check("stall_out", 16'(out4), 16'h06);
      check("stall_rdy", 16'(in_ready4), 16'd0);
    end
    @(posedge clk);
    #1 out_ready4 = 1'b1;
    in_valid4 = 1'b0;
    @(negedge clk);
    check("drain_hold", 16'(out4), 16'h06);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("drain_vld", 16'(out_valid4), 16'(c < 2));
      if (c < 2) check("drain_out", 16'(out4), c == 0 ? 16'h23 : 16'h18);
      if (c == 3) check("drain_busy", 16'(busy4), 16'd0);
    end
    for (int n = 0; n < 256 + LAT8 + 2; n++) begin
      int m;
      @(posedge clk);
      #1 in_valid8 = n < 256;
      if (n < 256) begin
        x8 = xa(n);
        y8 = yb(n);
      end
      @(negedge clk);
      m = n - LAT8;
      check("s8_rdy", 16'(in_ready8), 16'd1);
      check("s8_vld", 16'(out_valid8), 16'(m >= 0 && m < 256));
      if (m >= 0 && m < 256) check("s8_out", out8, exp8(m));
    end
    in_valid8 = 1'b0;
    @(posedge clk);
    #1 in_valid4 = 1'b1;
    x4 = 4'd3;
    y4 = 4'd3;
    @(posedge clk);
    #1 x4 = 4'd2;
    y4 = 4'd2;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("mid_vld", 16'(out_valid4), 16'd0);
    check("mid_out", 16'(out4), 16'd0);
    check("mid_busy", 16'(busy4), 16'd0);
    check("mid_rdy", 16'(in_ready4), 16'd1);
    check("mid_busy8", 16'(busy8), 16'd0);
    @(negedge clk);
    clr = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_vld", 16'(out_valid4), 16'd0);
    end
    run_one("new", 4'd3, 4'd5, 8'h0F);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
